lcd_text_ctrl_p: RTL and testbench

//  Parametrised HD44780-class character-LCD controller using the 4-bit write-only interface.

---
 rtl/lcd_text_ctrl_p.sv | 340 ++++++++++++++++++++++++++++++++++
 tb/tb_lcd_text_ctrl_p.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_ctrl_p.sv
// HD44780-class character LCD controller, 4-bit write-only interface.
// Runs the power-on init sequence, then refreshes a ROWS x COLS text buffer
// snapshotted at the start of every frame.
// Optional feature: define LCD_CHANGE_DETECT_EN to start a new frame only when
// row_data differs from the last snapshot (after the minimum T_FRAME gap).
module lcd_text_ctrl_p #(
    parameter int unsigned COLS    = 16,
    parameter int unsigned ROWS    = 2,
    parameter int unsigned T_PWR   = 750000,
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_EHIGH = 12,
    parameter int unsigned T_HOLD  = 2,
    parameter int unsigned T_NIB   = 50,
    parameter int unsigned T_CMD   = 2500,
    parameter int unsigned T_INIT  = 250000,
    parameter int unsigned T_CLR   = 100000,
    parameter int unsigned T_FRAME = 500000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ROWS*COLS*8-1:0]   row_data,
    output logic                     LCD_E,
    output logic                     LCD_RS,
    output logic                     LCD_RW,
    output logic [3:0]               LCD_D,
    output logic                     ready,
    output logic                     frame_done
);

    localparam int unsigned NCHAR = ROWS * COLS;
    localparam int unsigned NBITS = NCHAR * 8;

    // A zero timing parameter still costs one clock.
    function automatic int unsigned dly(input int unsigned t);
        return (t == 0) ? 1 : t;
    endfunction

    function automatic int unsigned t_max();
        int unsigned m;
        m = 1;
        if (T_PWR   > m) m = T_PWR;
        if (T_SETUP > m) m = T_SETUP;
        if (T_EHIGH > m) m = T_EHIGH;
        if (T_HOLD  > m) m = T_HOLD;
        if (T_NIB   > m) m = T_NIB;
        if (T_CMD   > m) m = T_CMD;
        if (T_INIT  > m) m = T_INIT;
        if (T_CLR   > m) m = T_CLR;
        if (T_FRAME > m) m = T_FRAME;
        return m;
    endfunction

    localparam int unsigned CNT_W = $clog2(t_max()) + 1;
    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;

    // Counter load values: a phase of N clocks loads N-1 and ends at zero.
    localparam logic [CNT_W-1:0] L_PWR   = CNT_W'(dly(T_PWR) - 1);
    localparam logic [CNT_W-1:0] L_SETUP = CNT_W'(dly(T_SETUP) - 1);
    localparam logic [CNT_W-1:0] L_EHIGH = CNT_W'(dly(T_EHIGH) - 1);
    localparam logic [CNT_W-1:0] L_HOLD  = CNT_W'(dly(T_HOLD) - 1);
    localparam logic [CNT_W-1:0] L_NIB   = CNT_W'(dly(T_NIB) - 1);
    localparam logic [CNT_W-1:0] L_CMD   = CNT_W'(dly(T_CMD) - 1);
    localparam logic [CNT_W-1:0] L_INIT  = CNT_W'(dly(T_INIT) - 1);
    localparam logic [CNT_W-1:0] L_CLR   = CNT_W'(dly(T_CLR) - 1);
    localparam logic [CNT_W-1:0] L_FRAME = CNT_W'(dly(T_FRAME) - 1);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [7:0]       FUNC_CMD = (ROWS > 1) ? 8'h28 : 8'h20;

    typedef enum logic [3:0] {
        StPwrWait, StInitNib, StFunc, StEntry, StDisp, StClear, StAddr, StData, StGap
    } state_e;

    typedef enum logic [2:0] {PhSetup, PhEhigh, PhHold, PhNib, PhPost} phase_e;

    state_e             st_q, st_d;
    phase_e             ph_q, ph_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               lo_q, lo_d;
    logic [7:0]         byte_q, byte_d;
    logic               rs_q, rs_d;
    logic [1:0]         init_q, init_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [NBITS-1:0]   snap_q, snap_d;
    logic               ready_q, ready_d;
    logic               fd_q, fd_d;
    logic               rw_q;

    logic               start, start_nib, start_rs, xfer_done, new_frame;
    logic [7:0]         start_val;
    logic [CNT_W-1:0]   post_load;
    logic [ROW_W-1:0]   row_nxt;
    logic [COL_W-1:0]   col_nxt;

    // Character r*COLS+c counted from the MSB byte of the buffer.
    function automatic logic [7:0] char_at(input logic [NBITS-1:0] text,
                                           input logic [ROW_W-1:0] r,
                                           input logic [COL_W-1:0] c);
        int unsigned      k;
        logic [NBITS-1:0] sh;
        k  = 32'(r) * COLS + 32'(c);
        sh = text << (k * 8);
        return sh[NBITS-1 -: 8];
    endfunction

    function automatic logic [7:0] addr_cmd(input logic [ROW_W-1:0] r);
        int unsigned b;
        case (32'(r))
            0:       b = 32'h00;
            1:       b = 32'h40;
            2:       b = COLS;
            default: b = 32'h40 + COLS;
        endcase
        return 8'(32'h80 + b);
    endfunction

    assign row_nxt = row_q + 1'b1;
    assign col_nxt = col_q + 1'b1;

    // Wait after the last E pulse of a transfer.
    always_comb begin
        post_load = L_CMD;
        if (st_q == StClear) begin
            post_load = L_CLR;
        end else if (st_q == StInitNib && init_q == 2'd0) begin
            post_load = L_INIT;
        end
    end

`ifdef LCD_CHANGE_DETECT_EN
    assign new_frame = (row_data != snap_q);
`else
    assign new_frame = 1'b1;
`endif

    // Next-state logic: nibble/byte engine plus the main sequencing FSM.
    always_comb begin
        st_d      = st_q;
        ph_d      = ph_q;
        cnt_d     = cnt_q;
        lo_d      = lo_q;
        byte_d    = byte_q;
        rs_d      = rs_q;
        init_d    = init_q;
        row_d     = row_q;
        col_d     = col_q;
        snap_d    = snap_q;
        ready_d   = ready_q;
        fd_d      = 1'b0;
        start     = 1'b0;
        start_nib = 1'b0;
        start_rs  = 1'b0;
        start_val = 8'h00;
        xfer_done = 1'b0;

        if (st_q != StPwrWait && st_q != StGap) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                case (ph_q)
                    PhSetup: begin
                        ph_d  = PhEhigh;
                        cnt_d = L_EHIGH;
                    end
                    PhEhigh: begin
                        ph_d  = PhHold;
                        cnt_d = L_HOLD;
                    end
                    PhHold: begin
                        if (!lo_q) begin
                            ph_d  = PhNib;
                            cnt_d = L_NIB;
                        end else begin
                            ph_d  = PhPost;
                            cnt_d = post_load;
                        end
                    end
                    PhNib: begin
                        ph_d  = PhSetup;
                        lo_d  = 1'b1;
                        cnt_d = L_SETUP;
                    end
                    default: xfer_done = 1'b1;
                endcase
            end
        end

        case (st_q)
            StPwrWait: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    st_d      = StInitNib;
                    init_d    = 2'd0;
                    start     = 1'b1;
                    start_nib = 1'b1;
                    start_val = 8'h33;
                end
            end
            StInitNib: begin
                if (xfer_done) begin
                    start = 1'b1;
                    if (init_q != 2'd3) begin
                        init_d    = init_q + 2'd1;
                        start_nib = 1'b1;
                        start_val = (init_q == 2'd2) ? 8'h22 : 8'h33;
                    end else begin
                        st_d      = StFunc;
                        start_val = FUNC_CMD;
                    end
                end
            end
            StFunc: begin
                if (xfer_done) begin
                    st_d      = StEntry;
                    start     = 1'b1;
                    start_val = 8'h06;
                end
            end
            StEntry: begin
                if (xfer_done) begin
                    st_d      = StDisp;
                    start     = 1'b1;
                    start_val = 8'h0C;
                end
            end
            StDisp: begin
                if (xfer_done) begin
                    st_d      = StClear;
                    start     = 1'b1;
                    start_val = 8'h01;
                end
            end
            StClear: begin
                if (xfer_done) begin
                    st_d      = StAddr;
                    ready_d   = 1'b1;
                    snap_d    = row_data;
                    row_d     = '0;
                    col_d     = '0;
                    start     = 1'b1;
                    start_val = addr_cmd('0);
                end
            end
            StAddr: begin
                if (xfer_done) begin
                    st_d      = StData;
                    col_d     = '0;
                    start     = 1'b1;
                    start_rs  = 1'b1;
                    start_val = char_at(snap_q, row_q, '0);
                end
            end
            StData: begin
                if (xfer_done) begin
                    if (col_q < COL_LAST) begin
                        col_d     = col_nxt;
                        start     = 1'b1;
                        start_rs  = 1'b1;
                        start_val = char_at(snap_q, row_q, col_nxt);
                    end else if (row_q < ROW_LAST) begin
                        st_d      = StAddr;
                        row_d     = row_nxt;
                        start     = 1'b1;
                        start_val = addr_cmd(row_nxt);
                    end else begin
                        st_d  = StGap;
                        fd_d  = 1'b1;
                        cnt_d = L_FRAME;
                    end
                end
            end
            StGap: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (new_frame) begin
                    st_d      = StAddr;
                    snap_d    = row_data;
                    row_d     = '0;
                    col_d     = '0;
                    start     = 1'b1;
                    start_val = addr_cmd('0);
                end
            end
            default: st_d = StPwrWait;
        endcase

        if (start) begin
            ph_d   = PhSetup;
            cnt_d  = L_SETUP;
            lo_d   = start_nib;
            byte_d = start_val;
            rs_d   = start_rs;
        end
    end

    // State registers; reset aborts any transfer and restarts at power-on wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= StPwrWait;
            ph_q    <= PhPost;
            cnt_q   <= L_PWR;
            lo_q    <= 1'b0;
            byte_q  <= 8'h00;
            rs_q    <= 1'b0;
            init_q  <= 2'd0;
            row_q   <= '0;
            col_q   <= '0;
            snap_q  <= '0;
            ready_q <= 1'b0;
            fd_q    <= 1'b0;
            rw_q    <= 1'b1;
        end else begin
            st_q    <= st_d;
            ph_q    <= ph_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            byte_q  <= byte_d;
            rs_q    <= rs_d;
            init_q  <= init_d;
            row_q   <= row_d;
            col_q   <= col_d;
            snap_q  <= snap_d;
            ready_q <= ready_d;
            fd_q    <= fd_d;
            rw_q    <= 1'b0;
        end
    end

    assign LCD_E      = (ph_q == PhEhigh);
    assign LCD_RS     = rs_q;
    assign LCD_RW     = rw_q;
    assign LCD_D      = lo_q ? byte_q[3:0] : byte_q[7:4];
    assign ready      = ready_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_lcd_text_ctrl_p.sv
// Self-checking bench for lcd_text_ctrl_p: a 2x2 instance and a 4x20 instance
// share one nibble monitor that feeds a scoreboard of expected LCD writes.
module tb_lcd_text_ctrl_p;

    logic        clk = 1'b0;
    logic        rst_n, rst4_n, sel;
    logic [31:0]  row_data;
    logic [639:0] row_data4;

    logic e2, rs2, rw2, rdy2, fd2;
    logic [3:0] d2;
    logic e4, rs4, rw4, rdy4, fd4;
    logic [3:0] d4;

    always #5 clk = ~clk;

    lcd_text_ctrl_p #(
        .COLS(2), .ROWS(2), .T_PWR(20), .T_SETUP(1), .T_EHIGH(2), .T_HOLD(1), .T_NIB(3),
        .T_CMD(5), .T_INIT(10), .T_CLR(8), .T_FRAME(6)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .row_data(row_data), .LCD_E(e2), .LCD_RS(rs2),
        .LCD_RW(rw2), .LCD_D(d2), .ready(rdy2), .frame_done(fd2)
    );

    lcd_text_ctrl_p #(
        .COLS(20), .ROWS(4), .T_PWR(20), .T_SETUP(1), .T_EHIGH(2), .T_HOLD(1), .T_NIB(3),
        .T_CMD(5), .T_INIT(10), .T_CLR(8), .T_FRAME(6)
    ) u_dut4 (
        .clk(clk), .rst_n(rst4_n), .row_data(row_data4), .LCD_E(e4), .LCD_RS(rs4),
        .LCD_RW(rw4), .LCD_D(d4), .ready(rdy4), .frame_done(fd4)
    );

    // Monitor view of the selected instance.
    logic mon_e, mon_rs, mon_rstn, mon_fd, mon_ready;
    logic [3:0] mon_d;
    assign mon_e     = sel ? e4    : e2;
    assign mon_rs    = sel ? rs4   : rs2;
    assign mon_d     = sel ? d4    : d2;
    assign mon_rstn  = sel ? rst4_n : rst_n;
    assign mon_fd    = sel ? fd4   : fd2;
    assign mon_ready = sel ? rdy4  : rdy2;

    typedef struct packed {
        logic       nib;
        logic       rs;
        logic [7:0] val;
    } item_t;

    typedef struct packed {
        logic [31:0] text;
        logic [47:0] bytes;
        logic [5:0]  rs;
    } vec_t;

    item_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;
    int e_rises = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Assemble E-rising captures into init nibbles / bytes and score them.
    int    nib_cnt = 0;
    logic  have_hi = 1'b0;
    logic  prev_e = 1'b0;
    logic [3:0] hi;
    item_t got, want;
    always @(negedge clk) begin
        if (!mon_rstn) begin
            nib_cnt = 0;
            have_hi = 1'b0;
            prev_e  = 1'b0;
        end else begin
            if (mon_fd) fd_cnt++;
            if (mon_e && !prev_e) begin
                e_rises++;
                if (nib_cnt < 4) begin
                    nib_cnt++;
                    got.nib = 1'b1;
                    got.rs  = mon_rs;
                    got.val = {4'h0, mon_d};
                end else if (!have_hi) begin
                    hi      = mon_d;
                    have_hi = 1'b1;
                end else begin
                    have_hi = 1'b0;
                    got.nib = 1'b0;
                    got.rs  = mon_rs;
                    got.val = {hi, mon_d};
                end
                if (!have_hi && exp_q.size() > 0) begin
                    want = exp_q.pop_front();
                    checks++;
                    if (got !== want) begin
                        errors++;
                        $display("FAIL lcd_write: got nib=%0d rs=%0d val=%02h expected nib=%0d rs=%0d val=%02h",
                                 got.nib, got.rs, got.val, want.nib, want.rs, want.val);
                    end
                end
            end
            prev_e = mon_e;
        end
    end

    task automatic push_item(input logic nib, input logic rs, input logic [7:0] val);
        item_t it;
        it.nib = nib;
        it.rs  = rs;
        it.val = val;
        exp_q.push_back(it);
    endtask

    task automatic push_init();
        push_item(1'b1, 1'b0, 8'h03);
        push_item(1'b1, 1'b0, 8'h03);
        push_item(1'b1, 1'b0, 8'h03);
        push_item(1'b1, 1'b0, 8'h02);
        push_item(1'b0, 1'b0, 8'h28);
        push_item(1'b0, 1'b0, 8'h06);
        push_item(1'b0, 1'b0, 8'h0C);
        push_item(1'b0, 1'b0, 8'h01);
    endtask

    task automatic push_frame2(input logic [31:0] txt);
        push_item(1'b0, 1'b0, 8'h80);
        push_item(1'b0, 1'b1, txt[31:24]);
        push_item(1'b0, 1'b1, txt[23:16]);
        push_item(1'b0, 1'b0, 8'hC0);
        push_item(1'b0, 1'b1, txt[15:8]);
        push_item(1'b0, 1'b1, txt[7:0]);
    endtask

    task automatic wait_fd(input string name, input int budget);
        int start;
        start = fd_cnt;
        for (int i = 0; i < budget && fd_cnt == start; i++) @(negedge clk);
        check(name, 32'(fd_cnt != start), 32'd1);
    endtask

    task automatic wait_ready(input string name);
        for (int i = 0; i < 1000 && !mon_ready; i++) @(negedge clk);
        check(name, 32'(mon_ready), 32'd1);
    endtask

    task automatic wait_data_e(input string name);
        for (int i = 0; i < 1000 && !(mon_e && mon_rs); i++) @(negedge clk);
        check(name, 32'(mon_e && mon_rs), 32'd1);
    endtask

    vec_t        vecs [4];
    vec_t        v;
    logic [31:0] txt;
    logic [7:0]  bases [4];
    int          quiet, fd0, e0;

    initial begin
        vecs[0] = '{text: "HI!?", bytes: {8'h80, "HI", 8'hC0, "!?"}, rs: 6'b011011};
        vecs[1] = '{text: "0123", bytes: {8'h80, "01", 8'hC0, "23"}, rs: 6'b011011};
        vecs[2] = '{text: "abcd", bytes: {8'h80, "ab", 8'hC0, "cd"}, rs: 6'b011011};
        vecs[3] = '{text: "Q  Z", bytes: {8'h80, "Q ", 8'hC0, " Z"}, rs: 6'b011011};
        bases[0] = 8'h80;
        bases[1] = 8'hC0;
        bases[2] = 8'h94;
        bases[3] = 8'hD4;

        sel      = 1'b0;
        rst_n    = 1'b0;
        rst4_n   = 1'b0;
        row_data = "ABCD";
        for (int k = 0; k < 80; k++) row_data4[(79 - k) * 8 +: 8] = 8'(32 + k);
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_E", 32'(e2), 32'd0);
        check("rst_RS", 32'(rs2), 32'd0);
        check("rst_RW", 32'(rw2), 32'd1);
        check("rst_D", 32'(d2), 32'd0);
        check("rst_ready", 32'(rdy2), 32'd0);
        check("rst_frame_done", 32'(fd2), 32'd0);

        // Init sequence and first frame
        push_init();
        txt = "ABCD";
        push_frame2(txt);
        rst_n = 1'b1;
        quiet = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (e2 || rw2) quiet++;
        end
        check("pwr_wait_quiet", 32'(quiet), 32'd0);
        check("ready_low_in_init", 32'(rdy2), 32'd0);
        wait_ready("ready_rise");
        check("init_stream_done_at_ready", 32'(exp_q.size()), 32'd6);
        fd0 = fd_cnt;
        wait_fd("frame1_done", 1000);
        check("frame1_drained", 32'(exp_q.size()), 32'd0);
        check("frame1_one_pulse", 32'(fd_cnt - fd0), 32'd1);

        // Table-driven text patterns, each loaded during the inter-frame gap
        for (int i = 0; i < 4; i++) begin
            v = vecs[i];
            row_data = v.text;
            for (int j = 0; j < 6; j++) push_item(1'b0, v.rs[5 - j], v.bytes[(5 - j) * 8 +: 8]);
            fd0 = fd_cnt;
            wait_fd("vec_frame_done", 1000);
            check("vec_drained", 32'(exp_q.size()), 32'd0);
            check("vec_one_pulse", 32'(fd_cnt - fd0), 32'd1);
        end

`ifndef LCD_CHANGE_DETECT_EN
        // Mid-frame change is held off until the next snapshot
        row_data = "ABCD";
        txt = "ABCD";
        push_frame2(txt);
        txt = "WXYZ";
        push_frame2(txt);
        wait_data_e("midframe_first_data");
        row_data = "WXYZ";
        wait_fd("midframe_frame_a", 1000);
        check("midframe_old_text_done", 32'(exp_q.size()), 32'd6);
        wait_fd("midframe_frame_b", 1000);
        check("midframe_new_text_done", 32'(exp_q.size()), 32'd0);
`else
        // Static data must not refresh; one changed byte yields exactly one frame
        fd0 = fd_cnt;
        e0  = e_rises;
        repeat (1000) @(negedge clk);
        check("static_no_E", 32'(e_rises - e0), 32'd0);
        check("static_no_frame", 32'(fd_cnt - fd0), 32'd0);
        txt = row_data;
        txt[7:0] = 8'h21;
        row_data = txt;
        push_frame2(txt);
        wait_fd("change_frame_done", 1000);
        check("change_drained", 32'(exp_q.size()), 32'd0);
        repeat (1000) @(negedge clk);
        check("change_one_frame", 32'(fd_cnt - fd0), 32'd1);
        check("change_E_pulses", 32'(e_rises - e0), 32'd12);
`endif

        // Reset during E-high of a data nibble
        wait_data_e("reset_target_nibble");
        rst_n = 1'b0;
        #1;
        check("abort_E", 32'(e2), 32'd0);
        check("abort_RW", 32'(rw2), 32'd1);
        check("abort_ready", 32'(rdy2), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        row_data = "ABCD";
        push_init();
        txt = "ABCD";
        push_frame2(txt);
        rst_n = 1'b1;
        wait_ready("restart_ready");
        check("restart_init_done", 32'(exp_q.size()), 32'd6);
        wait_fd("restart_frame_done", 1000);
        check("restart_drained", 32'(exp_q.size()), 32'd0);

        // 4x20 instance: row bases and 80 data bytes
        rst_n = 1'b0;
        @(negedge clk);
        sel = 1'b1;
        @(negedge clk);
        push_init();
        for (int r = 0; r < 4; r++) begin
            push_item(1'b0, 1'b0, bases[r]);
            for (int c = 0; c < 20; c++) push_item(1'b0, 1'b1, 8'(32 + r * 20 + c));
        end
        fd0 = fd_cnt;
        rst4_n = 1'b1;
        wait_fd("big_frame_done", 4000);
        check("big_drained", 32'(exp_q.size()), 32'd0);
        check("big_ready", 32'(rdy4), 32'd1);
        check("big_one_pulse", 32'(fd_cnt - fd0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
